// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: redirect/stall controls, instruction-memory port and IF/ID outputs of the fetch stage
interface if_fetch_stage_if #(parameter int CNT_W = 16);
  logic stall_i, branch_taken_i, jump_i;
  logic [31:0] branch_target_i, jump_target_i, imem_addr_o, imem_data_i;
  logic [31:0] if_id_instr_o, if_id_pc4_o;
  logic if_id_valid_o, misalign_o;
  logic [CNT_W-1:0] fetch_cnt_o, flush_cnt_o, stall_cnt_o;
  modport slave (
    input stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i, imem_data_i,
    output imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, misalign_o,
    output fetch_cnt_o, flush_cnt_o, stall_cnt_o
  );
  modport master (
    output stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i, imem_data_i,
    input imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, misalign_o,
    input fetch_cnt_o, flush_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, IF/ID register, redirect/stall handling and saturating counters
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  if_fetch_stage_if.slave f
);
  logic [31:0] pc_q, target;
  logic redirect;
  always_comb begin
    redirect = f.branch_taken_i | f.jump_i;
    target = f.branch_taken_i ? f.branch_target_i : f.jump_target_i;
  end
  assign f.imem_addr_o = pc_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      f.if_id_instr_o <= NOP_INSTR;
      f.if_id_pc4_o <= '0;
      f.if_id_valid_o <= 1'b0;
      f.misalign_o <= 1'b0;
      f.fetch_cnt_o <= '0;
      f.flush_cnt_o <= '0;
      f.stall_cnt_o <= '0;
    end else if (redirect) begin
      pc_q <= {target[31:2], 2'b00};
      f.if_id_instr_o <= NOP_INSTR;
      f.if_id_pc4_o <= '0;
      f.if_id_valid_o <= 1'b0;
      f.misalign_o <= f.misalign_o | (|target[1:0]);
      if (~&f.flush_cnt_o) f.flush_cnt_o <= f.flush_cnt_o + CNT_W'(1);
    end else if (f.stall_i) begin
      if (~&f.stall_cnt_o) f.stall_cnt_o <= f.stall_cnt_o + CNT_W'(1);
    end else begin
      pc_q <= pc_q + 32'd4;
      f.if_id_instr_o <= f.imem_data_i;
      f.if_id_pc4_o <= pc_q + 32'd4;
      f.if_id_valid_o <= 1'b1;
      if (~&f.fetch_cnt_o) f.fetch_cnt_o <= f.fetch_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed table, corner sequences and random run against a behavioural fetch model
module tb_if_fetch_stage;
  localparam int CW = 4;
  localparam int CMAX = 15;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  if_fetch_stage_if #(.CNT_W(CW)) f();
  if_fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .f(f));

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0: mem = 32'h2008_0001;
      32'h4: mem = 32'h2009_0006;
      32'h8: mem = 32'h2010_0064;
      32'hC: mem = 32'h2011_0000;
      32'h14: mem = 32'h0;
      default: mem = {~a[15:0], a[15:0]} ^ 32'h1234_0000;
    endcase
  endfunction
  assign f.imem_data_i = mem(f.imem_addr_o);

  typedef struct {
    logic r, s, b;
    logic [31:0] bt;
    logic j;
    logic [31:0] jt;
    logic [31:0] pc, instr, pc4;
    logic v, mis;
    int fc, flc, sc;
  } vec_t;
  vec_t tbl[15];

  logic [31:0] m_pc, m_instr, m_pc4, rbt, rjt;
  logic m_v, m_mis;
  int m_fc, m_flc, m_sc;
  int checks = 0, errors = 0;

  function automatic logic [31:0] sat(input int c);
    sat = (c > CMAX) ? 32'(CMAX) : 32'(c);
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    logic [31:0] t;
    reset = r; f.stall_i = s; f.branch_taken_i = b; f.branch_target_i = bt;
    f.jump_i = j; f.jump_target_i = jt;
    @(posedge clk);
    if (!r) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_v = 0; m_mis = 0; m_fc = 0; m_flc = 0; m_sc = 0;
    end else if (b || j) begin
      t = b ? bt : jt;
      if (t % 4 != 0) m_mis = 1;
      m_pc = t - (t % 4);
      m_instr = 0; m_pc4 = 0; m_v = 0; m_flc++;
    end else if (s) begin
      m_sc++;
    end else begin
      m_instr = mem(m_pc); m_pc4 = m_pc + 4; m_v = 1; m_pc = m_pc + 4; m_fc++;
    end
    #1;
    chk("imem_addr", f.imem_addr_o, m_pc);
    chk("instr", f.if_id_instr_o, m_instr);
    chk("pc4", f.if_id_pc4_o, m_pc4);
    chk("valid", 32'(f.if_id_valid_o), 32'(m_v));
    chk("misalign", 32'(f.misalign_o), 32'(m_mis));
    chk("fetch_cnt", 32'(f.fetch_cnt_o), sat(m_fc));
    chk("flush_cnt", 32'(f.flush_cnt_o), sat(m_flc));
    chk("stall_cnt", 32'(f.stall_cnt_o), sat(m_sc));
  endtask

  initial begin
    tbl[0]  = '{1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h0, 32'h0,          32'h0, 1'b0,1'b0, 0,0,0};
    tbl[1]  = '{1'b1,1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h4, 32'h2008_0001,  32'h4, 1'b1,1'b0, 1,0,0};
    tbl[2]  = '{1'b1,1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h8, 32'h2009_0006,  32'h8, 1'b1,1'b0, 2,0,0};
    tbl[3]  = '{1'b1,1'b0,1'b0,32'h0, 1'b0,32'h0,  32'hC, 32'h2010_0064,  32'hC, 1'b1,1'b0, 3,0,0};
    tbl[4]  = '{1'b1,1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h10,32'h2011_0000,  32'h10,1'b1,1'b0, 4,0,0};
    tbl[5]  = '{1'b1,1'b1,1'b0,32'h0, 1'b0,32'h0,  32'h10,32'h2011_0000,  32'h10,1'b1,1'b0, 4,0,1};
    tbl[6]  = '{1'b1,1'b1,1'b0,32'h0, 1'b0,32'h0,  32'h10,32'h2011_0000,  32'h10,1'b1,1'b0, 4,0,2};
    tbl[7]  = '{1'b1,1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h14,32'hEDDB_0010,  32'h14,1'b1,1'b0, 5,0,2};
    tbl[8]  = '{1'b1,1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h18,32'h0,          32'h18,1'b1,1'b0, 6,0,2};
    tbl[9]  = '{1'b1,1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h1C,32'hEDD3_0018,  32'h1C,1'b1,1'b0, 7,0,2};
    tbl[10] = '{1'b1,1'b0,1'b1,32'h30,1'b0,32'h0,  32'h30,32'h0,          32'h0, 1'b0,1'b0, 7,1,2};
    tbl[11] = '{1'b1,1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h34,32'hEDFB_0030,  32'h34,1'b1,1'b0, 8,1,2};
    tbl[12] = '{1'b1,1'b1,1'b1,32'h34,1'b1,32'h10, 32'h34,32'h0,          32'h0, 1'b0,1'b0, 8,2,2};
    tbl[13] = '{1'b1,1'b0,1'b0,32'h0, 1'b1,32'h12, 32'h10,32'h0,          32'h0, 1'b0,1'b1, 8,3,2};
    tbl[14] = '{1'b1,1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h14,32'hEDDB_0010,  32'h14,1'b1,1'b1, 9,3,2};
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].bt, tbl[i].j, tbl[i].jt);
      chk($sformatf("tbl%0d_pc", i), f.imem_addr_o, tbl[i].pc);
      chk($sformatf("tbl%0d_instr", i), f.if_id_instr_o, tbl[i].instr);
      chk($sformatf("tbl%0d_pc4", i), f.if_id_pc4_o, tbl[i].pc4);
      chk($sformatf("tbl%0d_valid", i), 32'(f.if_id_valid_o), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_mis", i), 32'(f.misalign_o), 32'(tbl[i].mis));
      chk($sformatf("tbl%0d_fc", i), 32'(f.fetch_cnt_o), sat(tbl[i].fc));
      chk($sformatf("tbl%0d_flc", i), 32'(f.flush_cnt_o), sat(tbl[i].flc));
      chk($sformatf("tbl%0d_sc", i), 32'(f.stall_cnt_o), sat(tbl[i].sc));
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("misalign_sticky", 32'(f.misalign_o), 32'h1);
    end
    chk("fetch_sat", 32'(f.fetch_cnt_o), 32'd15);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stall_mid", 32'(f.stall_cnt_o), 32'd3);
    step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    chk("rst_pc", f.imem_addr_o, 32'h0);
    chk("rst_valid", 32'(f.if_id_valid_o), 32'h0);
    chk("rst_mis", 32'(f.misalign_o), 32'h0);
    chk("rst_cnts", 32'({f.fetch_cnt_o, f.flush_cnt_o, f.stall_cnt_o}), 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("wrap_pc", f.imem_addr_o, 32'h0);
    chk("wrap_pc4", f.if_id_pc4_o, 32'h0);
    chk("wrap_valid", 32'(f.if_id_valid_o), 32'h1);
    for (int i = 0; i < 600; i++) begin
      rbt = $urandom; rjt = $urandom;
      if ($urandom_range(3) != 0) rbt[1:0] = 2'b00;
      if ($urandom_range(3) != 0) rjt[1:0] = 2'b00;
      step($urandom_range(31) != 0, $urandom_range(3) == 0, $urandom_range(7) == 0, rbt,
           $urandom_range(7) == 0, rjt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC register and drives the instruction-memory byte address. It also owns the IF/ID pipeline register that feeds the decode stage.
It applies stall, branch and jump redirects from the hazard/branch logic, inserting NOP bubbles on flush. It keeps saturating performance counters that the stress benches read to check flush and stall behaviour.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
NOP_INSTR, 32'h0000_0000, encoding injected into IF/ID on a flush.
CNT_W, 16, width of each performance counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
stall_i  input  1  load-use stall from the hazard unit; hold PC and IF/ID
branch_taken_i  input  1  BEQ resolved taken in ID
branch_target_i  input  32  branch target byte address
jump_i  input  1  J decoded in ID
jump_target_i  input  32  jump target byte address
imem_addr_o  output  32  byte address to instruction memory; equals pc_q
imem_data_i  input  32  instruction word returned combinationally for imem_addr_o
if_id_instr_o  output  32  IF/ID instruction
if_id_pc4_o  output  32  IF/ID PC+4
if_id_valid_o  output  1  1 = IF/ID holds a real fetched instruction
misalign_o  output  1  sticky; a redirect target had bits [1:0] != 0
fetch_cnt_o  output  CNT_W  instructions latched into IF/ID with valid=1
flush_cnt_o  output  CNT_W  cycles in which a redirect flushed IF/ID
stall_cnt_o  output  CNT_W  cycles in which a stall held the stage

Behaviour:
- Reset (reset==0 at a rising edge): sets the following regardless of other inputs.
  - pc_q=RESET_PC.
  - if_id_instr_o=NOP_INSTR, if_id_pc4_o=0, if_id_valid_o=0.
  - misalign_o=0 and all counters=0.
  - Reset asserted mid-operation discards any pending redirect or stall.
- imem_addr_o=pc_q combinationally. There is no registered read: the instruction is latched into IF/ID at the end of the cycle in which it is addressed (1-cycle IF latency).
- redirect = branch_taken_i | jump_i.
- Per-cycle priority, highest first: reset > branch_taken_i > jump_i > stall_i > sequential.
- Branch wins over a simultaneous jump, because the branch is the older instruction. In that case jump_target_i is ignored.
- Redirect wins over stall_i. In that case the stall is ignored for that cycle and stall_cnt_o does not increment.
- On a redirect:
  - pc_q <= {target[31:2],2'b00}.
  - IF/ID <= {NOP_INSTR, pc4=0, valid=0}; the wrong-path fetch is squashed (one bubble).
  - flush_cnt_o++.
  - If target[1:0]!=0, set misalign_o (sticky until reset).
- On a stall (no redirect): pc_q and all IF/ID fields hold their values; stall_cnt_o++.
- Sequential (no redirect, no stall):
  - pc_q <= pc_q+4, with 32-bit wrap: 32'hFFFF_FFFC -> 0.
  - IF/ID <= {imem_data_i, pc_q+4, valid=1}; fetch_cnt_o++.
- An imem_data_i value equal to NOP_INSTR is still a valid fetch (valid=1, counted).
- Counters saturate at all-ones and never wrap.
- Only one counter increments in any cycle.
- No combinational path from imem_data_i to any output; all IF/ID outputs are registered.

Test Plan:
1. Reset then free-run 4 cycles, imem returning 0x20080001, 0x20090006, 0x20100064, 0x20110000 -> imem_addr 0,4,8,C. The IF/ID sequence must be, with valid=1 and fetch_cnt=4:
   - (0x20080001, pc4=4)
   - (0x20090006, pc4=8)
   - (0x20100064, pc4=C)
   - (0x20110000, pc4=0x10)
2. With pc_q=0x10, hold stall_i=1 for 2 cycles -> pc_q stays 0x10 and IF/ID unchanged. Then stall_cnt=2; on release the fetch resumes at 0x10.
3. branch_taken_i=1, target=0x30 while pc_q=0x1C -> next pc_q=0x30 and IF/ID={0,0,valid=0}, flush_cnt=1. The following cycle latches the instruction at 0x30 with pc4=0x34.
4. branch_taken_i=1 (target 0x34) and jump_i=1 (target 0x10) together with stall_i=1 -> pc_q=0x34, flush_cnt+1, stall_cnt unchanged.
5. jump_i=1, target=0x12 -> pc_q=0x10 and misalign_o=1. misalign_o stays 1 for 20 cycles and clears only on reset.
6. With CNT_W=4, run 20 sequential cycles -> fetch_cnt_o saturates at 15. Then assert reset mid-stall -> all outputs return to their reset values on the next edge.
